// File: rtl/imem_fetch_responder_pkg.sv
// Shared widths and FSM encoding for the instruction-fetch responder.
// The SRAM lives outside the responder; only its bus widths are shared here.
package param_defs;
  localparam int DataWidth     = 32;
  localparam int MemBusWidth   = 32;
  localparam int ImemAddrWidth = 12;

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RSP} imem_rsp_state_e;

  // RISC-V: a halfword whose low two bits are not 2'b11 is a 16-bit instruction
  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/imem_fetch_responder.sv
// Instruction fetch responder: turns byte-address fetches into one or two SRAM
// word reads and returns a 16- or 32-bit instruction with a compressed flag.
module imem_fetch_responder #(
  parameter int DataWidth     = param_defs::DataWidth,
  parameter int ImemAddrWidth = param_defs::ImemAddrWidth
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [DataWidth-1:0]             req_addr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_data,
  output logic                             rsp_compressed,
  output logic                             rsp_err,
  output logic                             mem_en,
  output logic [ImemAddrWidth-1:0]         mem_addr,
  input  logic [param_defs::MemBusWidth-1:0] mem_rd
);
  import param_defs::*;

  imem_rsp_state_e           state_q, state_d;
  logic                      addr1_q, addr1_d;
  logic [ImemAddrWidth-1:0]  widx_q, widx_d;
  logic [15:0]               half_q, half_d;
  logic [31:0]               data_q, data_d;
  logic                      comp_q, comp_d;
  logic                      err_q, err_d;
  logic                      accept, span_rd;
  logic                      unused_addr;

  // Bits above the SRAM index only select the byte-address space, not a word
  assign unused_addr = ^req_addr[DataWidth-1:ImemAddrWidth+2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr1_q <= 1'b0;
      widx_q  <= '0;
      half_q  <= '0;
      data_q  <= '0;
      comp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr1_q <= addr1_d;
      widx_q  <= widx_d;
      half_q  <= half_d;
      data_q  <= data_d;
      comp_q  <= comp_d;
      err_q   <= err_d;
    end
  end

  // Next state and response formation
  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    widx_d  = widx_q;
    half_d  = half_q;
    data_d  = data_q;
    comp_d  = comp_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        addr1_d = req_addr[1];
        widx_d  = req_addr[ImemAddrWidth+1:2];
        if (req_addr[0]) begin
          state_d = RSP;
          data_d  = '0;
          comp_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        err_d = 1'b0;
        if (!addr1_q) begin
          state_d = RSP;
          comp_d  = is_compressed(mem_rd[15:0]);
          data_d  = comp_d ? {16'h0, mem_rd[15:0]} : mem_rd[31:0];
        end else if (is_compressed(mem_rd[31:16])) begin
          state_d = RSP;
          comp_d  = 1'b1;
          data_d  = {16'h0, mem_rd[31:16]};
        end else begin
          state_d = RD_HI;
          half_d  = mem_rd[31:16];
        end
      end
      RD_HI: begin
        state_d = RSP;
        data_d  = {mem_rd[15:0], half_q};
        comp_d  = 1'b0;
        err_d   = 1'b0;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; the second read of a spanning fetch is issued while the first word is on mem_rd
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    accept    = req_valid && req_ready;
    span_rd   = (state_q == RD_LO) && addr1_q && !is_compressed(mem_rd[31:16]) && !rst;
    mem_en    = (accept && !req_addr[0]) || span_rd;
    mem_addr  = span_rd ? widx_q + ImemAddrWidth'(1) : req_addr[ImemAddrWidth+1:2];
    rsp_valid = (state_q == RSP);
  end

  assign rsp_data       = data_q;
  assign rsp_compressed = comp_q;
  assign rsp_err        = err_q;
endmodule
